// File: rtl/mem_port_if.sv
// ---------------------------------------------------------------------------
// mem_port_if
// Bundles the signals around the shared memory port: the instruction-fetch
// request/response, the MEM-stage request/response, the pipeline stall
// outputs, and the registered RAM-side request with its completion.
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives responses, stalls
//            and the RAM request; takes the RAM response)
//   master - the surrounding pipeline/RAM view (mirror of slave)
//
// Signals:
//   if_req, if_addr                  fetch request and address
//   if_rdata, if_done                fetch data and one-cycle completion
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        MEM-stage load/store request
//   mem_rdata, mem_done              load data and one-cycle completion
//   stall_if, stall_pipe             pipeline freeze controls
//   ram_req, ram_we, ram_addr,
//   ram_wdata                        registered RAM request
//   ram_rdata, ram_ready             RAM read data and completion strobe
//   bus_err                          one-cycle timeout-abort indication
// ---------------------------------------------------------------------------
interface mem_port_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  logic          stall_if;
  logic          stall_pipe;

  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready;

  logic          bus_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    output if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_pipe,
           ram_req, ram_we, ram_addr, ram_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    input  if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_pipe,
           ram_req, ram_we, ram_addr, ram_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between instruction fetch and the MEM
// stage. Grants one requester at a time, holds a registered RAM request
// until ram_ready (or a wait timeout), returns data with a one-cycle done
// pulse, and produces the stalls that freeze the pipeline meanwhile.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_if.slave: fetch/MEM requests and responses, stall
//          outputs, registered RAM request, RAM response, bus_err
//
// Parameters:
//   AW, DW    address / data width
//   TIMEOUT   wait cycles in a grant before abort (1..255)
//   ERR_DATA  read data returned by an aborted read
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF, RESP} state_t;
  typedef enum logic       {GRANT_IF, GRANT_MEM}         grant_t;

  // A grant aborts on the ready-less edge at which the counter would reach
  // TIMEOUT, so ram_req stays high for exactly TIMEOUT wait cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q,     state_d;
  grant_t        last_q,      last_d;
  logic [7:0]    wait_q,      wait_d;
  logic          ram_req_q,   ram_req_d;
  logic          ram_we_q,    ram_we_d;
  logic [AW-1:0] ram_addr_q,  ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          if_done_q,   if_done_d;
  logic          mem_done_q,  mem_done_d;
  logic          bus_err_q,   bus_err_d;

  logic          pick_mem;
  logic          finish;
  logic [DW-1:0] rsp_data;

  // MEM wins unless IF is also asking and MEM was served last.
  assign pick_mem = bus.mem_req && (!bus.if_req || last_q == GRANT_IF);
  assign finish   = bus.ram_ready || (wait_q == WAIT_LAST);
  assign rsp_data = bus.ram_ready ? bus.ram_rdata : ERR_DATA;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    wait_d      = wait_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_mem) begin
          state_d     = GNT_MEM;
          last_d      = GRANT_MEM;
          wait_d      = '0;
          ram_req_d   = 1'b1;
          ram_we_d    = bus.mem_we;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
        end else if (bus.if_req) begin
          state_d     = GNT_IF;
          last_d      = GRANT_IF;
          wait_d      = '0;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = bus.if_addr;
          ram_wdata_d = '0;
        end
      end

      GNT_MEM, GNT_IF: begin
        if (finish) begin
          state_d   = RESP;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          bus_err_d = !bus.ram_ready;
          if (state_q == GNT_MEM) begin
            mem_done_d = 1'b1;
            // Stores leave the last load data in place.
            if (!ram_we_q) mem_rdata_d = rsp_data;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = rsp_data;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      // Done-pulse cycle; always back to IDLE so the completing
      // instruction's still-high request is not granted again here.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: read-data holding registers are cleared by reset too, so the
  // visible outputs are defined zeros rather than X until first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= GRANT_IF;
      wait_q      <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      last_q      <= last_d;
      wait_q      <= wait_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.stall_if   = bus.if_req  & ~if_done_q;
  assign bus.stall_pipe = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (TIMEOUT = 4). A small RAM responder
// raises ram_ready a programmable number of wait cycles after ram_req rises;
// each task drives one scenario and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // RAM responder controls.
  bit            ram_auto    = 1'b1;
  int            ram_lat     = 0;
  logic [DW-1:0] ram_data    = '0;
  bit            xor_addr    = 1'b0;
  bit            force_ready = 1'b0;

  initial begin : responder
    int waited;
    waited        = 0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ram_ready = force_ready;
      if (bus.ram_req && ram_auto) begin
        if (waited == ram_lat) begin
          bus.ram_ready = 1'b1;
          bus.ram_rdata = ram_data ^ (xor_addr ? bus.ram_addr : '0);
          waited        = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL reset_ram_req: got %0b want 0", bus.ram_req); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %0b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_wdata: got %h want 0", bus.ram_wdata); end
    checks++; if (bus.if_rdata !== 32'h0) begin failures++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
    checks++; if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
    checks++; if ({bus.if_done, bus.mem_done, bus.bus_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b want 000", {bus.if_done, bus.mem_done, bus.bus_err}); end
    checks++; if ({bus.stall_if, bus.stall_pipe} !== 2'b00) begin failures++; $display("FAIL reset_stalls: got %b want 00", {bus.stall_if, bus.stall_pipe}); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got ram_req=%0b want 0", bus.ram_req); end
  endtask

  task automatic test_isolated_load();
    int req_cycles;
    ram_auto = 1'b1; ram_lat = 3; ram_data = 32'h1234_5678; xor_addr = 1'b0;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h100; bus.mem_wdata = '0;
    #1;
    checks++; if (bus.stall_pipe !== 1'b1) begin failures++; $display("FAIL load_stall_comb: got %0b want 1", bus.stall_pipe); end
    req_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (bus.ram_req === 1'b1) req_cycles++;
      if (i == 1) begin
        checks++; if ({bus.ram_we, bus.ram_addr} !== {1'b0, 32'h100}) begin failures++; $display("FAIL load_ram_cmd: got we=%0b addr=%h want we=0 addr=100", bus.ram_we, bus.ram_addr); end
      end
      checks++; if (bus.mem_done !== (i == 5)) begin failures++; $display("FAIL load_done_c%0d: got %0b want %0b", i, bus.mem_done, (i == 5)); end
      checks++; if (bus.stall_pipe !== (i != 5)) begin failures++; $display("FAIL load_stall_c%0d: got %0b want %0b", i, bus.stall_pipe, (i != 5)); end
    end
    checks++; if (req_cycles != 4) begin failures++; $display("FAIL load_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (bus.mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL load_rdata: got %h want 12345678", bus.mem_rdata); end
    checks++; if ({bus.bus_err, bus.if_done} !== 2'b00) begin failures++; $display("FAIL load_side_pulses: got %b want 00", {bus.bus_err, bus.if_done}); end
    bus.mem_req = 1'b0;
    tick();
    checks++; if ({bus.mem_done, bus.ram_req} !== 2'b00) begin failures++; $display("FAIL load_after: got done,req=%b want 00", {bus.mem_done, bus.ram_req}); end
    checks++; if (bus.mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL load_rdata_hold: got %h want 12345678", bus.mem_rdata); end
    tick();
  endtask

  task automatic test_store();
    ram_auto = 1'b1; ram_lat = 0; ram_data = 32'h5555_5555; xor_addr = 1'b0;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hCAFE_F00D;
    tick();
    checks++; if ({bus.ram_req, bus.ram_we} !== 2'b11) begin failures++; $display("FAIL store_req_we: got %b want 11", {bus.ram_req, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 32'h40) begin failures++; $display("FAIL store_addr: got %h want 40", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL store_wdata: got %h want cafef00d", bus.ram_wdata); end
    checks++; if (bus.mem_done !== 1'b0) begin failures++; $display("FAIL store_done_early: got %0b want 0", bus.mem_done); end
    tick();
    checks++; if ({bus.mem_done, bus.ram_req, bus.ram_we} !== 3'b100) begin failures++; $display("FAIL store_done: got done,req,we=%b want 100", {bus.mem_done, bus.ram_req, bus.ram_we}); end
    checks++; if (bus.mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL store_rdata_kept: got %h want 12345678", bus.mem_rdata); end
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick();
    checks++; if (bus.mem_done !== 1'b0) begin failures++; $display("FAIL store_single_pulse: got %0b want 0", bus.mem_done); end
    tick();
  endtask

  task automatic test_contention();
    int  at   [4];
    bit  kind [4];
    bit  exp_kind [4];
    int  n, mem_dones, if_dones;
    bit  prev_req;
    exp_kind = '{1'b1, 1'b0, 1'b1, 1'b0};
    at   = '{0, 0, 0, 0};
    kind = '{1'b0, 1'b0, 1'b0, 1'b0};
    ram_auto = 1'b1; ram_lat = 0; xor_addr = 1'b0;
    rst_n = 1'b0;
    bus.if_req = 1'b1;  bus.if_addr = 32'h1000;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h2000;
    tick();
    rst_n = 1'b1;
    n = 0; mem_dones = 0; if_dones = 0; prev_req = 1'b0;
    for (int i = 1; i <= 30 && n < 4; i++) begin
      tick();
      if (bus.mem_done === 1'b1) mem_dones++;
      if (bus.if_done === 1'b1) if_dones++;
      if (bus.ram_req === 1'b1 && !prev_req) begin
        kind[n] = (bus.ram_addr === 32'h2000);
        at[n]   = i;
        n++;
      end
      prev_req = (bus.ram_req === 1'b1);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL cont_grant_count: got %0d want 4 within 30 cycles", n); end
    checks++; if (at[0] != 1) begin failures++; $display("FAIL cont_first_grant: got cycle %0d want 1", at[0]); end
    for (int k = 0; k < n; k++) begin
      checks++; if (kind[k] != exp_kind[k]) begin failures++; $display("FAIL cont_order_%0d: got mem=%0b want mem=%0b", k, kind[k], exp_kind[k]); end
      if (k > 0) begin
        checks++; if (at[k] - at[k-1] != 3) begin failures++; $display("FAIL cont_gap_%0d: got %0d want 3", k, at[k] - at[k-1]); end
      end
    end
    checks++; if ({mem_dones, if_dones} !== {32'd2, 32'd1}) begin failures++; $display("FAIL cont_dones: got mem=%0d if=%0d want mem=2 if=1", mem_dones, if_dones); end
    idle_inputs();
    tick(); tick(); tick();
    checks++; if (bus.ram_req !== 1'b0) begin failures++; $display("FAIL cont_drain: got ram_req=%0b want 0", bus.ram_req); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    ram_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h3000;
    req_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (bus.ram_req === 1'b1) req_cycles++;
      checks++; if ({bus.if_done, bus.bus_err} !== {(i == 5), (i == 5)}) begin failures++; $display("FAIL tmo_pulse_c%0d: got done,err=%b want %b", i, {bus.if_done, bus.bus_err}, {(i == 5), (i == 5)}); end
    end
    checks++; if (req_cycles != 4) begin failures++; $display("FAIL tmo_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (bus.if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL tmo_rdata: got %h want deadbeef", bus.if_rdata); end
    checks++; if (bus.mem_done !== 1'b0) begin failures++; $display("FAIL tmo_mem_done: got %0b want 0", bus.mem_done); end
    // A stray ram_ready while no grant is open must be ignored.
    bus.if_req = 1'b0;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick();
    checks++; if ({bus.if_done, bus.mem_done, bus.bus_err, bus.ram_req} !== 4'b0000) begin failures++; $display("FAIL stray_ready: got %b want 0000", {bus.if_done, bus.mem_done, bus.bus_err, bus.ram_req}); end
    checks++; if (bus.if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stray_ready_rdata: got %h want deadbeef", bus.if_rdata); end
    ram_auto = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int  done_at;
    bit  early_done;
    ram_auto = 1'b1; ram_lat = 10; ram_data = 32'h0BAD_0000; xor_addr = 1'b0;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h500;
    tick();
    checks++; if (bus.ram_req !== 1'b1) begin failures++; $display("FAIL rmid_granted: got %0b want 1", bus.ram_req); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.ram_req, bus.ram_addr} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rmid_async_drop: got req=%0b addr=%h want 0 0", bus.ram_req, bus.ram_addr); end
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    early_done = 1'b0;
    tick();
    if (bus.mem_done === 1'b1) early_done = 1'b1;
    ram_lat = 1;
    rst_n = 1'b1;
    tick();
    if (bus.mem_done === 1'b1) early_done = 1'b1;
    checks++; if (early_done !== 1'b0) begin failures++; $display("FAIL rmid_no_done: got mem_done during/after reset want none"); end
    checks++; if ({bus.ram_req, bus.ram_addr} !== {1'b1, 32'h500}) begin failures++; $display("FAIL rmid_tie_mem: got req=%0b addr=%h want 1 500", bus.ram_req, bus.ram_addr); end
    done_at = 0;
    for (int i = 2; i <= 10 && done_at == 0; i++) begin
      tick();
      if (bus.mem_done === 1'b1) done_at = i;
    end
    checks++; if (done_at != 3) begin failures++; $display("FAIL rmid_done_cycle: got %0d want 3", done_at); end
    checks++; if (bus.mem_rdata !== 32'h0BAD_0000) begin failures++; $display("FAIL rmid_rdata: got %h want 0bad0000", bus.mem_rdata); end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int            done_at [4];
    int            nd;
    bit            prev_req;
    logic [AW-1:0] addr_at_edge;
    logic [AW-1:0] granted_addr;
    done_at = '{0, 0, 0, 0};
    ram_auto = 1'b1; ram_lat = 0; ram_data = 32'hF00D_0000; xor_addr = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    nd = 0; prev_req = 1'b0; granted_addr = '0;
    for (int i = 1; i <= 24 && nd < 4; i++) begin
      addr_at_edge = bus.if_addr;
      tick();
      if (bus.ram_req === 1'b1 && !prev_req) begin
        granted_addr = addr_at_edge;
        checks++; if ({bus.ram_we, bus.ram_addr} !== {1'b0, addr_at_edge}) begin failures++; $display("FAIL b2b_addr_c%0d: got we=%0b addr=%h want we=0 addr=%h", i, bus.ram_we, bus.ram_addr, addr_at_edge); end
      end
      if (bus.if_done === 1'b1) begin
        done_at[nd] = i;
        checks++; if (bus.if_rdata !== (32'hF00D_0000 ^ granted_addr)) begin failures++; $display("FAIL b2b_rdata_%0d: got %h want %h", nd, bus.if_rdata, 32'hF00D_0000 ^ granted_addr); end
        nd++;
      end
      prev_req = (bus.ram_req === 1'b1);
      bus.if_addr = 32'h10 + 32'(4 * i);
    end
    checks++; if (nd != 4) begin failures++; $display("FAIL b2b_done_count: got %0d want 4 within 24 cycles", nd); end
    checks++; if (done_at[0] != 2) begin failures++; $display("FAIL b2b_first_done: got cycle %0d want 2", done_at[0]); end
    for (int k = 1; k < nd; k++) begin
      checks++; if (done_at[k] - done_at[k-1] != 3) begin failures++; $display("FAIL b2b_period_%0d: got %0d want 3", k, done_at[k] - done_at[k-1]); end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin : main
    idle_inputs();
    test_reset();
    test_isolated_load();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
